// File: rtl/sseg_pkg.sv
// Shared types, hex segment table and decode helper for the 7-segment scanner.
package sseg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; bit 7 is replaced by the decimal point on decode.
  localparam seg_t SEG_HEX_LUT [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble, input logic dp);
    seg_t lut;
    lut = SEG_HEX_LUT[nibble];
    return {~dp, lut[6:0]};
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sseg_pwm_timer.sv
// Slot/digit timebase for the scanner: capture strobe, dead-time window and PWM gate.
module sseg_pwm_timer
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int TICK_DIV    = 1024,
  parameter int DEAD_CYCLES = 16,
  parameter int PWM_BITS    = 4,
  localparam int IDX_W      = idx_width(NUM_DIGITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] sh_bright,
  output logic [IDX_W-1:0]    digit_idx,
  output logic                cap_stb,
  output logic                dead_ok,
  output logic                pwm_on
);

  localparam int SLOT_W = $clog2(TICK_DIV);

  logic [SLOT_W-1:0] slot_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (&slot_cnt) begin
        if (digit_idx == IDX_W'(NUM_DIGITS - 1))
          digit_idx <= '0;
        else
          digit_idx <= digit_idx + 1'b1;
      end
    end
  end

  // Capture at the very first cycle of a frame; that cycle is always inside dead time.
  assign cap_stb = (slot_cnt == '0) && (digit_idx == '0);
  assign dead_ok = (slot_cnt >= SLOT_W'(DEAD_CYCLES));
  assign pwm_on  = (&sh_bright) || (slot_cnt[PWM_BITS-1:0] < sh_bright);

endmodule

// File: rtl/sseg_scan.sv
// Multiplexed hex 7-segment driver with PWM dimming, anode dead time and frame-locked capture.
// Optional blinking via macro SSEG_BLINK_EN (adds blink_mask port and BLINK_FRAMES parameter).
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int TICK_DIV    = 1024,
  parameter int DEAD_CYCLES = 16,
  parameter int PWM_BITS    = 4
`ifdef SSEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [PWM_BITS-1:0]     brightness,
`ifdef SSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [7:0]              sseg,
  output logic [7:0]              an,
  output logic                    frame_start
);

  localparam int IDX_W = idx_width(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [PWM_BITS-1:0]     sh_bright;
  logic [IDX_W-1:0]        digit_idx;
  logic                    cap_stb;
  logic                    dead_ok;
  logic                    pwm_on;
  logic                    blank_eff;
  logic                    en_p0;
  logic [3:0]              nib_p0;
  logic [7:0]              an_dec_p0;
  seg_t                    sseg_p1;
  logic [7:0]              an_p1;
  logic                    fs_p1;

  sseg_pwm_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .TICK_DIV   (TICK_DIV),
    .DEAD_CYCLES(DEAD_CYCLES),
    .PWM_BITS   (PWM_BITS)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .sh_bright(sh_bright),
    .digit_idx(digit_idx),
    .cap_stb  (cap_stb),
    .dead_ok  (dead_ok),
    .pwm_on   (pwm_on)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      sh_bright <= '0;
    end else if (cap_stb) begin
      sh_digits <= digits;
      sh_dp     <= dp_in;
      sh_blank  <= blank_mask;
      sh_bright <= brightness;
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int FC_W = $clog2(BLINK_FRAMES + 1);

  logic [NUM_DIGITS-1:0] sh_blink;
  logic [FC_W-1:0]       frm_cnt;
  logic                  blink_phase;

  // frm_cnt holds captures seen in the current phase; the phase flips on the capture that opens a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_blink    <= '0;
      frm_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (cap_stb) begin
      sh_blink <= blink_mask;
      if (frm_cnt == FC_W'(BLINK_FRAMES)) begin
        frm_cnt     <= FC_W'(1);
        blink_phase <= ~blink_phase;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  assign blank_eff = sh_blank[digit_idx] | (blink_phase & sh_blink[digit_idx]);
`else
  assign blank_eff = sh_blank[digit_idx];
`endif

  // Stage p0: enable decision and decode from the current slot
  assign en_p0     = dead_ok & pwm_on & ~blank_eff;
  assign nib_p0    = sh_digits[4*digit_idx +: 4];
  assign an_dec_p0 = ~(8'b1 << digit_idx);

  // Stage p1: registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg_p1 <= SEG_BLANK;
      an_p1   <= 8'hFF;
      fs_p1   <= 1'b0;
    end else begin
      fs_p1 <= cap_stb;
      if (en_p0) begin
        sseg_p1 <= hex_to_seg(nib_p0, sh_dp[digit_idx]);
        an_p1   <= an_dec_p0;
      end else begin
        sseg_p1 <= SEG_BLANK;
        an_p1   <= 8'hFF;
      end
    end
  end

  assign sseg        = sseg_p1;
  assign an          = an_p1;
  assign frame_start = fs_p1;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed bench for sseg_scan: 4 digits, 64-cycle slots, 2 dead cycles, 4-bit PWM.
module tb_sseg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [3:0]  brightness;
`ifdef SSEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif
  logic [7:0]  sseg;
  logic [7:0]  an;
  logic        frame_start;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_seg [4];
  int         exp_low [4];

  always #5 clk = ~clk;

  sseg_scan #(
    .NUM_DIGITS (4),
    .TICK_DIV   (64),
    .DEAD_CYCLES(2),
    .PWM_BITS   (4)
`ifdef SSEG_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .brightness (brightness),
`ifdef SSEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .sseg       (sseg),
    .an         (an),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_exp(input logic [31:0] segs, input int l0, input int l1, input int l2, input int l3);
    exp_seg[0] = segs[7:0];
    exp_seg[1] = segs[15:8];
    exp_seg[2] = segs[23:16];
    exp_seg[3] = segs[31:24];
    exp_low[0] = l0;
    exp_low[1] = l1;
    exp_low[2] = l2;
    exp_low[3] = l3;
  endtask

  // One frame = 256 samples; sample j shows the decision made at slot j%64 of digit j/64.
  task automatic observe_frame(input string name, input int chg_j, input logic [15:0] chg_val);
    int         lowc [4];
    logic [7:0] seen [4];
    int segbad = 0, idlebad = 0, multi = 0, upper = 0, dead = 0, fsbad = 0, order = 0;
    logic fs_first = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lowc[i] = 0;
      seen[i] = 8'h00;
    end
    for (int j = 0; j < 256; j++) begin
      @(negedge clk);
      if (j == chg_j) digits = chg_val;
      if (j == 0) fs_first = frame_start;
      else if (frame_start) fsbad++;
      if (an[7:4] != 4'hF) upper++;
      if ($countones(~an[3:0]) > 1) multi++;
      if ((j % 64) < 2 && an != 8'hFF) dead++;
      if (an == 8'hFF && sseg != 8'hFF) idlebad++;
      for (int i = 0; i < 4; i++) begin
        if (!an[i]) begin
          lowc[i]++;
          seen[i] = sseg;
          if (sseg != exp_seg[i]) segbad++;
          if (i != j / 64) order++;
        end
      end
    end
    chk({name, " frame_start at slot0"}, 32'(fs_first), 32'd1);
    chk({name, " frame_start elsewhere"}, fsbad, 0);
    chk({name, " an[7:4] low"}, upper, 0);
    chk({name, " multiple anodes low"}, multi, 0);
    chk({name, " dead-time anode low"}, dead, 0);
    chk({name, " sseg not blank while dark"}, idlebad, 0);
    chk({name, " anode out of scan order"}, order, 0);
    chk({name, " sseg mismatches"}, segbad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s digit%0d low cycles", name, i), lowc[i], exp_low[i]);
      if (exp_low[i] > 0)
        chk($sformatf("%s digit%0d sseg", name, i), seen[i], exp_seg[i]);
    end
  endtask

  initial begin
    int nf;
    int l0;
    rst        = 1'b1;
    digits     = 16'h0A5F;
    dp_in      = 4'b0000;
    blank_mask = 4'b0000;
    brightness = 4'hF;
`ifdef SSEG_BLINK_EN
    blink_mask = 4'b0000;
`endif

    repeat (3) @(negedge clk);
    chk("reset sseg", sseg, 8'hFF);
    chk("reset an", an, 8'hFF);
    chk("reset frame_start", frame_start, 1'b0);
    rst = 1'b0;

    // Mid-frame change during digit2 must not show until the next frame.
    set_exp({8'hC0, 8'h88, 8'h92, 8'h8E}, 62, 62, 62, 62);
    observe_frame("hex0A5F", 140, 16'h1234);
    set_exp({8'hF9, 8'hA4, 8'hB0, 8'h99}, 62, 62, 62, 62);
    observe_frame("hex1234", -1, 16'h0);

    digits     = 16'h0A5F;
    brightness = 4'h4;
    set_exp({8'hC0, 8'h88, 8'h92, 8'h8E}, 14, 14, 14, 14);
    observe_frame("pwm4", -1, 16'h0);

    brightness = 4'h0;
    set_exp({8'hC0, 8'h88, 8'h92, 8'h8E}, 0, 0, 0, 0);
    observe_frame("pwm0", -1, 16'h0);

    brightness = 4'hF;
    dp_in      = 4'b0100;
    blank_mask = 4'b1000;
    set_exp({8'hC0, 8'h08, 8'h92, 8'h8E}, 62, 62, 62, 0);
    observe_frame("dpblank", -1, 16'h0);

    dp_in      = 4'b0000;
    blank_mask = 4'b0000;
    for (int j = 0; j < 140; j++) @(negedge clk);
    chk("pre-reset digit2 an", an, 8'hFB);
    chk("pre-reset digit2 sseg", sseg, 8'h88);
    rst = 1'b1;
    #1;
    chk("async reset an", an, 8'hFF);
    chk("async reset sseg", sseg, 8'hFF);
    repeat (2) @(negedge clk);
    chk("held reset frame_start", frame_start, 1'b0);
    chk("held reset an", an, 8'hFF);
`ifdef SSEG_BLINK_EN
    blink_mask = 4'b0001;
    nf = 5;
`else
    nf = 1;
`endif
    rst = 1'b0;
    for (int f = 0; f < nf; f++) begin
      l0 = 62;
`ifdef SSEG_BLINK_EN
      if (f == 2 || f == 3) l0 = 0;
`endif
      set_exp({8'hC0, 8'h88, 8'h92, 8'h8E}, l0, 62, 62, 62);
      observe_frame($sformatf("postreset%0d", f), -1, 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
